score_accumulator: RTL and testbench
====================================

SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of decimal display digits.
REQ-002 Parameter SCORE_W, default 14: score register width, SHALL satisfy 2^SCORE_W > 10^NUM_DIGITS-1.
REQ-003 Parameter LINES_PER_LEVEL, default 10: cleared lines per level increment.
REQ-004 Parameter MAX_LEVEL, default 15: level saturation value; LEVEL_W = 4.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 gameState  in  1  1 = game running, 0 = hold everything at zero.
REQ-008 clearValid  in  1  line-clear event valid.
REQ-009 clearRows  in  3  rows cleared by the event, legal 0..4.
REQ-010 clearReady  out  1  event accepted when clearValid && clearReady at an edge.
REQ-011 digits  out  4 x NUM_DIGITS  BCD score, digits[0] least significant.
REQ-012 digitsValid  out  1  digits reflects current score.
REQ-013 level  out  LEVEL_W  current level.
REQ-014 saturated  out  1  sticky: score clipped at 10^NUM_DIGITS-1 this game.

Function
REQ-015 FSM states IDLE, UPDATE, CONVERT; clearReady = 1 only in IDLE with gameState = 1.
REQ-016 IDLE: accepted event with clearRows 1..4 -> UPDATE; clearRows 0 -> accepted, no state change, stays IDLE; clearRows 5..7 -> accepted and discarded, no state change.
REQ-017 Base points: 1 -> 100, 2 -> 300, 3 -> 500, 4 -> 800; 4 with b2b flag set -> 1200.
REQ-018 UPDATE (one cycle): score <= min(score + base*(level+1), 10^NUM_DIGITS-1), computed at SCORE_W+8 bits with no intermediate truncation; clipping sets saturated.
REQ-019 UPDATE: b2b flag <= (clearRows == 4); a clearRows-0 event leaves b2b unchanged.
REQ-020 UPDATE: lines counter += clearRows; each crossing of a LINES_PER_LEVEL multiple increments level, saturating at MAX_LEVEL; new level applies from the next event.
REQ-021 UPDATE -> CONVERT; digitsValid drops to 0 on that edge; binary-to-BCD conversion takes exactly SCORE_W cycles.
REQ-022 Latency: event accepted at edge N -> score updated at N+1 -> digits updated, digitsValid = 1, FSM in IDLE at edge N+SCORE_W+2.
REQ-023 digits holds its previous value during CONVERT.
REQ-024 gameState = 0 at any edge: score, lines, level, b2b, saturated cleared; digits = all 0; digitsValid = 1; FSM -> IDLE; any in-flight conversion aborted; no event accepted.
REQ-025 gameState rising: first event is accepted at the following edge; scoring starts from level 0.

Reset
REQ-026 rst_n low asynchronously forces: FSM IDLE, score 0, lines 0, level 0, b2b 0, saturated 0, digits all 0, digitsValid 1.
REQ-027 clearReady SHALL be 0 while rst_n is low and for the first edge after release.
REQ-028 Reset mid-CONVERT discards the conversion; no partial digits SHALL appear.

Structure
REQ-029 Package tetris_pkg holds the FSM state enum, base-points constants (100/300/500/800/1200) and a BCD digit typedef (4 bits).
REQ-030 One sub-module bin2bcd_seq: shift-add-3 converter, parameters SCORE_W and NUM_DIGITS, start/busy/done, asynchronous active-low reset.
REQ-031 No division or modulo operators SHALL be synthesised.

Verification
REQ-032 Level 0, one event rows = 1 -> digits 0100 at edge N+16, digitsValid low for 15 cycles.
REQ-033 Rows = 4 twice at level 0 -> score 800, then 2000 (b2b 1200); digits 2000.
REQ-034 Ten singles (1000 points), then a single -> level = 1, score 1200; a rows = 0 event between two tetrises keeps b2b active (800 + 1200).
REQ-035 Score 9900, level 3, rows = 4 -> digits 9999, saturated = 1.
REQ-036 gameState low during CONVERT -> next edge digits 0000, digitsValid 1, level 0; rst_n pulse mid-CONVERT -> same values immediately.
REQ-037 clearRows = 6 accepted -> no score change, clearReady stays 1.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the line-clear score accumulator.
package tetris_pkg;

   localparam int unsigned LEVEL_W = 4;

   localparam int unsigned PtsSingle    = 100;
   localparam int unsigned PtsDouble    = 300;
   localparam int unsigned PtsTriple    = 500;
   localparam int unsigned PtsTetris    = 800;
   localparam int unsigned PtsTetrisB2b = 1200;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      StIdle,
      StUpdate,
      StConvert
   } acc_state_e;

   // Elaboration-time 10^n; keeps the saturation limit free of any divider.
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// Loads on start, shifts for SCORE_W cycles, then holds done until the next cycle.
module bin2bcd_seq
   import tetris_pkg::*;
#(
   parameter int unsigned SCORE_W    = 14,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [SCORE_W-1:0]      bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);

   localparam int unsigned BcdW = 4 * NUM_DIGITS;
   localparam int unsigned CntW = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0]          shift_q, shift_d;
   bcd_digit_t [NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic                        busy_q, busy_d;

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
      end
   end

   always_comb begin
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (abort) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         shift_d = bin;
         bcd_d   = '0;
         cnt_d   = CntW'(SCORE_W);
         busy_d  = 1'b1;
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            // Top digit's carry-out is dropped: the score never exceeds the digit range.
            bcd_d   = BcdW'({bcd_adj, shift_q[SCORE_W-1]});
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CntW'(1);
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == '0);
   assign bcd  = bcd_q;

endmodule

// File: rtl/score_accumulator.sv
// Line-clear score accumulator: scores events by level and back-to-back bonus,
// tracks level progression and presents the saturating score as BCD digits.
module score_accumulator
   import tetris_pkg::*;
#(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned SCORE_W         = 14,
   parameter int unsigned LINES_PER_LEVEL = 10,
   parameter int unsigned MAX_LEVEL       = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    gameState,
   input  logic                    clearValid,
   input  logic [2:0]              clearRows,
   output logic                    clearReady,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    digitsValid,
   output logic [LEVEL_W-1:0]      level,
   output logic                    saturated
);

   localparam int unsigned ExtW     = SCORE_W + 8;
   localparam int unsigned MaxScore = pow10(NUM_DIGITS) - 1;
   localparam int unsigned LinesW   = $clog2(LINES_PER_LEVEL + 4) + 1;

   acc_state_e              state_q, state_d;
   logic [2:0]              rows_q, rows_d;
   logic [SCORE_W-1:0]      score_q, score_d, score_new;
   logic [LinesW-1:0]       lines_q, lines_d, lines_new;
   logic [LEVEL_W-1:0]      level_q, level_d, level_new;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d, conv_bcd;
   logic                    b2b_q, b2b_d, sat_q, sat_d, dv_q, dv_d, rdy_q;
   logic [ExtW-1:0]         base_pts, sum_ext;
   logic                    clip, accept, scoring_event;
   logic                    conv_start, conv_abort, conv_busy, conv_done;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (scoring_event) state_d = StUpdate;
         StUpdate:  state_d = StConvert;
         StConvert: if (conv_done || !conv_busy) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      if (!gameState) state_d = StIdle;
   end

   // FSM: outputs
   always_comb begin
      clearReady    = (state_q == StIdle) && gameState && rdy_q;
      accept        = clearValid && clearReady;
      scoring_event = accept && (clearRows != 3'd0) && (clearRows <= 3'd4);
      conv_start    = (state_q == StUpdate);
      conv_abort    = !gameState;
   end

   // Score arithmetic runs wide so the clip test sees the true sum.
   always_comb begin
      case (rows_q)
         3'd1:    base_pts = ExtW'(PtsSingle);
         3'd2:    base_pts = ExtW'(PtsDouble);
         3'd3:    base_pts = ExtW'(PtsTriple);
         3'd4:    base_pts = b2b_q ? ExtW'(PtsTetrisB2b) : ExtW'(PtsTetris);
         default: base_pts = '0;
      endcase
      sum_ext   = ExtW'(score_q) + base_pts * (ExtW'(level_q) + ExtW'(1));
      clip      = sum_ext > ExtW'(MaxScore);
      score_new = clip ? SCORE_W'(MaxScore) : sum_ext[SCORE_W-1:0];
   end

   // lines_q counts lines within the current level; subtract instead of modulo.
   always_comb begin
      lines_new = lines_q + LinesW'(rows_q);
      level_new = level_q;
      for (int i = 0; i < 4; i++) begin
         if (lines_new >= LinesW'(LINES_PER_LEVEL)) begin
            lines_new = lines_new - LinesW'(LINES_PER_LEVEL);
            if (level_new != LEVEL_W'(MAX_LEVEL)) level_new = level_new + LEVEL_W'(1);
         end
      end
   end

   always_comb begin
      rows_d   = rows_q;
      score_d  = score_q;
      lines_d  = lines_q;
      level_d  = level_q;
      b2b_d    = b2b_q;
      sat_d    = sat_q;
      digits_d = digits_q;
      dv_d     = dv_q;
      if (!gameState) begin
         rows_d   = '0;
         score_d  = '0;
         lines_d  = '0;
         level_d  = '0;
         b2b_d    = 1'b0;
         sat_d    = 1'b0;
         digits_d = '0;
         dv_d     = 1'b1;
      end else begin
         if (scoring_event) rows_d = clearRows;
         if (state_q == StUpdate) begin
            score_d = score_new;
            lines_d = lines_new;
            level_d = level_new;
            b2b_d   = (rows_q == 3'd4);
            sat_d   = sat_q | clip;
            dv_d    = 1'b0;
         end
         if (state_q == StConvert && state_d == StIdle) begin
            dv_d = 1'b1;
            if (conv_done) digits_d = conv_bcd;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_q   <= '0;
         score_q  <= '0;
         lines_q  <= '0;
         level_q  <= '0;
         b2b_q    <= 1'b0;
         sat_q    <= 1'b0;
         digits_q <= '0;
         dv_q     <= 1'b1;
      end else begin
         rows_q   <= rows_d;
         score_q  <= score_d;
         lines_q  <= lines_d;
         level_q  <= level_d;
         b2b_q    <= b2b_d;
         sat_q    <= sat_d;
         digits_q <= digits_d;
         dv_q     <= dv_d;
      end
   end

   // Holds off acceptance for the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   bin2bcd_seq #(
      .SCORE_W   (SCORE_W),
      .NUM_DIGITS(NUM_DIGITS)
   ) u_bin2bcd (
      .clk  (clk),
      .rst_n(rst_n),
      .start(conv_start),
      .abort(conv_abort),
      .bin  (score_new),
      .busy (conv_busy),
      .done (conv_done),
      .bcd  (conv_bcd)
   );

   assign digits      = digits_q;
   assign digitsValid = dv_q;
   assign level       = level_q;
   assign saturated   = sat_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Scoreboard bench for score_accumulator: a behavioural scoring model predicts
// digits, completion cycle, level and saturation for every scoring event.
module tb_score_accumulator;

   localparam int unsigned Lat = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        gameState = 1'b0;
   logic        clearValid = 1'b0;
   logic [2:0]  clearRows = 3'd0;
   logic        clearReady;
   logic [15:0] digits;
   logic        digitsValid;
   logic [3:0]  level;
   logic        saturated;

   typedef struct {
      logic [15:0] dig;
      int unsigned cyc;
      int unsigned lvl;
      logic        sat;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned m_score = 0;
   int unsigned m_lines = 0;
   logic        m_b2b = 1'b0;
   logic        m_sat = 1'b0;

   score_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gameState  (gameState),
      .clearValid (clearValid),
      .clearRows  (clearRows),
      .clearReady (clearReady),
      .digits     (digits),
      .digitsValid(digitsValid),
      .level      (level),
      .saturated  (saturated)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int unsigned m_level();
      int unsigned l;
      l = m_lines / 10;
      return (l > 15) ? 15 : l;
   endfunction

   task automatic model_event(input int rows);
      int unsigned base, s;
      if (rows < 1 || rows > 4) return;
      case (rows)
         1:       base = 100;
         2:       base = 300;
         3:       base = 500;
         default: base = m_b2b ? 1200 : 800;
      endcase
      s = m_score + base * (m_level() + 1);
      if (s > 9999) begin
         s = 9999;
         m_sat = 1'b1;
      end
      m_score = s;
      m_b2b = (rows == 4);
      m_lines += rows;
   endtask

   task automatic model_clear();
      m_score = 0;
      m_lines = 0;
      m_b2b = 1'b0;
      m_sat = 1'b0;
   endtask

   // Completion monitor: pops one expectation per digitsValid rising edge.
   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && gameState === 1'b1 && digitsValid === 1'b1 && prev === 1'b0) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: digitsValid rose at cycle %0d, none pending", cyc);
            end else begin
               e = sb.pop_front();
               total++;
               if (cyc !== e.cyc) begin
                  bad++;
                  $display("FAIL done_cycle: got %0d want %0d", cyc, e.cyc);
               end
               total++;
               if (digits !== e.dig) begin
                  bad++;
                  $display("FAIL done_digits: got %h want %h", digits, e.dig);
               end
               total++;
               if (level !== 4'(e.lvl)) begin
                  bad++;
                  $display("FAIL done_level: got %0d want %0d", level, e.lvl);
               end
               total++;
               if (saturated !== e.sat) begin
                  bad++;
                  $display("FAIL done_saturated: got %b want %b", saturated, e.sat);
               end
            end
         end
         prev = digitsValid;
      end
   end

   task automatic send(input int rows);
      exp_t e;
      @(negedge clk);
      total++;
      if (clearReady !== 1'b1) begin
         bad++;
         $display("FAIL ready_before_send: got %b want 1", clearReady);
      end
      clearValid = 1'b1;
      clearRows = 3'(rows);
      model_event(rows);
      if (rows >= 1 && rows <= 4) begin
         e.dig = to_bcd(m_score);
         e.cyc = cyc + 1 + Lat;
         e.lvl = m_level();
         e.sat = m_sat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      clearValid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: pending %0d want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic send_wait(input int rows, input string name);
      send(rows);
      wait_done(name);
   endtask

   task automatic restart_game();
      @(negedge clk);
      gameState = 1'b0;
      @(negedge clk);
      gameState = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      gameState = 1'b1;
      #2;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (clearReady !== 1'b0 || digitsValid !== 1'b1 || digits !== 16'h0000 ||
          level !== 4'd0 || saturated !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: rdy=%b dv=%b dig=%h lvl=%0d sat=%b want 0 1 0000 0 0",
                  clearReady, digitsValid, digits, level, saturated);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (clearReady !== 1'b0) begin
         bad++;
         $display("FAIL ready_first_edge: got %b want 0", clearReady);
      end
      @(posedge clk);
      #1;
      total++;
      if (clearReady !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_release: got %b want 1", clearReady);
      end
   endtask

   task automatic test_single();
      send(1);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (digitsValid !== 1'b0 || clearReady !== 1'b0 || digits !== 16'h0000) begin
         bad++;
         $display("FAIL single_convert: dv=%b rdy=%b dig=%h want 0 0 0000",
                  digitsValid, clearReady, digits);
      end
      wait_done("single");
      total++;
      if (digits !== 16'h0100) begin
         bad++;
         $display("FAIL single_digits: got %h want 0100", digits);
      end
   endtask

   task automatic test_tetris_b2b();
      restart_game();
      send_wait(4, "tetris1");
      send(4);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (digits !== 16'h0800 || digitsValid !== 1'b0) begin
         bad++;
         $display("FAIL tetris_hold: dig=%h dv=%b want 0800 0", digits, digitsValid);
      end
      wait_done("tetris2");
      total++;
      if (digits !== 16'h2000) begin
         bad++;
         $display("FAIL tetris_b2b: got %h want 2000", digits);
      end
   endtask

   task automatic test_level();
      restart_game();
      for (int i = 0; i < 10; i++) send_wait(1, "level_single");
      total++;
      if (level !== 4'd1 || digits !== 16'h1000) begin
         bad++;
         $display("FAIL level_up: lvl=%0d dig=%h want 1 1000", level, digits);
      end
      send_wait(1, "level_next");
      total++;
      if (digits !== 16'h1200) begin
         bad++;
         $display("FAIL level_score: got %h want 1200", digits);
      end
      restart_game();
      send_wait(4, "b2b_first");
      send(0);
      total++;
      if (clearReady !== 1'b1 || digitsValid !== 1'b1) begin
         bad++;
         $display("FAIL rows0_idle: rdy=%b dv=%b want 1 1", clearReady, digitsValid);
      end
      send_wait(4, "b2b_second");
      total++;
      if (digits !== 16'h2000) begin
         bad++;
         $display("FAIL rows0_keeps_b2b: got %h want 2000", digits);
      end
   endtask

   task automatic test_saturate();
      restart_game();
      for (int i = 0; i < 20; i++) send_wait(1, "sat_single");
      for (int i = 0; i < 5; i++) send_wait(2, "sat_double");
      for (int i = 0; i < 6; i++) send_wait(1, "sat_single3");
      total++;
      if (digits !== 16'h9900 || level !== 4'd3 || saturated !== 1'b0) begin
         bad++;
         $display("FAIL sat_setup: dig=%h lvl=%0d sat=%b want 9900 3 0", digits, level, saturated);
      end
      send_wait(4, "sat_tetris");
      total++;
      if (digits !== 16'h9999 || saturated !== 1'b1) begin
         bad++;
         $display("FAIL saturate: dig=%h sat=%b want 9999 1", digits, saturated);
      end
   endtask

   task automatic test_invalid_rows();
      int errs;
      restart_game();
      send_wait(2, "inv_double");
      send(6);
      total++;
      if (clearReady !== 1'b1 || digitsValid !== 1'b1) begin
         bad++;
         $display("FAIL rows6_idle: rdy=%b dv=%b want 1 1", clearReady, digitsValid);
      end
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (digitsValid !== 1'b1 || digits !== 16'h0300) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL rows6_no_change: %0d bad cycles want 0", errs);
      end
      send_wait(1, "inv_after");
      total++;
      if (digits !== 16'h0400) begin
         bad++;
         $display("FAIL rows6_after: got %h want 0400", digits);
      end
   endtask

   task automatic test_abort_game();
      restart_game();
      for (int i = 0; i < 10; i++) send_wait(1, "abort_single");
      send(1);
      repeat (5) @(negedge clk);
      sb.delete();
      gameState = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (digits !== 16'h0000 || digitsValid !== 1'b1 || level !== 4'd0 ||
          saturated !== 1'b0 || clearReady !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: dig=%h dv=%b lvl=%0d sat=%b rdy=%b want 0000 1 0 0 0",
                  digits, digitsValid, level, saturated, clearReady);
      end
      repeat (20) @(negedge clk);
      gameState = 1'b1;
      model_clear();
      #1;
      total++;
      if (clearReady !== 1'b1) begin
         bad++;
         $display("FAIL restart_ready: got %b want 1", clearReady);
      end
      send_wait(1, "restart_single");
      total++;
      if (digits !== 16'h0100 || level !== 4'd0) begin
         bad++;
         $display("FAIL restart_score: dig=%h lvl=%0d want 0100 0", digits, level);
      end
   endtask

   task automatic test_reset_mid();
      int errs;
      restart_game();
      for (int i = 0; i < 10; i++) send_wait(1, "rst_single");
      send(2);
      repeat (4) @(negedge clk);
      sb.delete();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (digits !== 16'h0000 || digitsValid !== 1'b1 || level !== 4'd0 ||
          saturated !== 1'b0 || clearReady !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: dig=%h dv=%b lvl=%0d sat=%b rdy=%b want 0000 1 0 0 0",
                  digits, digitsValid, level, saturated, clearReady);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      errs = 0;
      repeat (25) begin
         @(negedge clk);
         if (digitsValid !== 1'b1 || digits !== 16'h0000) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL reset_mid_partial: %0d bad cycles want 0", errs);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tetris_b2b();
      test_level();
      test_saturate();
      test_invalid_rows();
      test_abort_game();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
